// File: rtl/data_sram_like_bridge_if.sv
// Split-transaction sram-like data bus: request phase (req/addr_ok) and response phase (data_ok).
interface data_sram_like_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge.sv
// Bridges single-cycle M-stage data_sram strobes onto the split-transaction sram-like bus,
// stalling the pipeline while a transfer is in flight and holding the read word until advance.
module data_sram_like_bridge #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            data_sram_en,
    input  logic [3:0]                      data_sram_wen,
    input  logic [31:0]                     data_sram_addr,
    input  logic [31:0]                     data_sram_wdata,
    output logic [31:0]                     data_sram_rdata,
    input  logic                            flush,
    input  logic                            advance,
    output logic                            mem_stall,
    data_sram_like_bridge_if.master         bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;

    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [29:0] pa_word;
    logic [1:0]  req_low;
    logic [1:0]  req_size;
    logic        start;

    assign start = (state == S_IDLE) && data_sram_en && !flush;

    // Physical word address plus size/low-bit encoding derived from the byte strobes.
    always_comb begin
        pa_word  = data_sram_addr[31:2];
        req_low  = 2'b00;
        req_size = 2'd2;
        if (MAP_KSEG && (data_sram_addr[31:30] == 2'b10)) begin
            pa_word = {3'b000, data_sram_addr[28:2]};
        end
        if (|data_sram_wen) begin
            case (data_sram_wen)
                4'b0011: req_size = 2'd1;
                4'b1100: begin req_size = 2'd1; req_low = 2'b10; end
                4'b0001: req_size = 2'd0;
                4'b0010: begin req_size = 2'd0; req_low = 2'b01; end
                4'b0100: begin req_size = 2'd0; req_low = 2'b10; end
                4'b1000: begin req_size = 2'd0; req_low = 2'b11; end
                default: req_size = 2'd2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_ADDR;
            S_ADDR: begin
                if (bus.data_addr_ok) state_next = flush ? S_DRAIN : S_DATA;
                else if (flush)       state_next = S_IDLE;
            end
            S_DATA: begin
                if (flush)                 state_next = bus.data_data_ok ? S_IDLE : S_DRAIN;
                else if (bus.data_data_ok) state_next = S_DONE;
            end
            S_DRAIN: if (bus.data_data_ok) state_next = S_IDLE;
            S_DONE:  if (advance || flush) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request fields are frozen from IDLE until the next access; only reads update the held word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            req_q <= (state_next == S_ADDR);
            if (start) begin
                wr_q    <= |data_sram_wen;
                size_q  <= req_size;
                addr_q  <= {pa_word, req_low};
                wdata_q <= data_sram_wdata;
            end
            if ((state == S_DATA) && bus.data_data_ok && !flush && !wr_q) begin
                rdata_q <= bus.data_rdata;
            end
        end
    end

    assign mem_stall = resetn && (start || (state == S_ADDR) || (state == S_DATA) ||
                                  (state == S_DRAIN));

    assign bus.data_req     = req_q;
    assign bus.data_wr      = wr_q;
    assign bus.data_size    = size_q;
    assign bus.data_addr    = addr_q;
    assign bus.data_wdata   = wdata_q;
    assign data_sram_rdata  = rdata_q;

endmodule
